// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the EX-stage multiply/divide unit: RV32M op codes,
// forwarding selects (same encoding the ALU muxes use), result select and FSM states.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    FROM_IDEX  = 2'd0,
    FROM_EXMEM = 2'd1,
    FROM_MEMWB = 2'd2
  } forward_t;

  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_Q,
    SEL_R
  } res_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the muldiv unit (slave).
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import ex_muldiv_unit_pkg::*;

  logic             start;
  muldiv_op_t       op;
  forward_t         opa_fw;
  forward_t         opb_fw;
  logic [WIDTH-1:0] rs1_out;
  logic [WIDTH-1:0] rs2_out;
  logic [WIDTH-1:0] from_exmem;
  logic [WIDTH-1:0] from_memwb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, opa_fw, opb_fw, rs1_out, rs2_out, from_exmem, from_memwb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, opa_fw, opb_fw, rs1_out, rs2_out, from_exmem, from_memwb, flush,
    output busy, done, result
  );

endinterface

// File: rtl/ex_muldiv_unit_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes.
// Divider datapath is only built when EX_MULDIV_DIV_EN is defined.
module ex_muldiv_unit_muldiv_core #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EX_MULDIV_DIV_EN
  input  logic             i_is_div,
`endif
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_lo_init,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  localparam int K  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // hi:lo is the running product; the multiplier is consumed from lo[0]
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    return {s[WIDTH:1], s[0], lo[WIDTH-1:1]};
  endfunction

`ifdef EX_MULDIV_DIV_EN
  logic r_is_div;

  // hi is the partial remainder, lo shifts the dividend out and quotient bits in
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    r = {hi, lo[WIDTH-1]};
    q = {lo[WIDTH-2:0], 1'b0};
    if (r >= {1'b0, m}) begin
      r    = r - {1'b0, m};
      q[0] = 1'b1;
    end
    return {r[WIDTH-1:0], q};
  endfunction
`endif

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef EX_MULDIV_DIV_EN
      if (r_is_div) {w_hi_next, w_lo_next} = div_step(w_hi_next, w_lo_next, r_m);
      else
`endif
      {w_hi_next, w_lo_next} = mul_step(w_hi_next, w_lo_next, r_m);
    end
  end

  // The final iteration is consumed combinationally by the owner, so only K-1 are stored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
`ifdef EX_MULDIV_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_lo_init;
      r_m    <= i_m;
      r_cnt  <= '0;
`ifdef EX_MULDIV_DIV_EN
      r_is_div <= i_is_div;
`endif
    end else if (i_step) begin
      r_hi   <= w_hi_next;
      r_lo   <= w_lo_next;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_hi   = w_hi_next;
  assign o_lo   = w_lo_next;
  assign o_last = (r_cnt == CW'(K - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: operand forwarding/capture, sign handling and control FSM.
// Define EX_MULDIV_DIV_EN to build the divider and its divide-by-zero/overflow fast path.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  ex_muldiv_unit_if.slave   bus
);

  logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_core_hi, w_core_lo, w_fast_res, w_calc_res;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic               w_a_neg, w_b_neg, w_neg, w_is_div, w_fast, w_load, w_core_last;
  res_sel_t           w_sel;

  state_t             r_state;
  res_sel_t           r_sel;
  logic               r_neg, r_busy, r_done;
  logic [WIDTH-1:0]   r_result;

  // Forwarding muxes and magnitude/sign extraction for the requested op
  always_comb begin
    case (bus.opa_fw)
      FROM_EXMEM: w_a = bus.from_exmem;
      FROM_MEMWB: w_a = bus.from_memwb;
      default:    w_a = bus.rs1_out;
    endcase
    case (bus.opb_fw)
      FROM_EXMEM: w_b = bus.from_exmem;
      FROM_MEMWB: w_b = bus.from_memwb;
      default:    w_b = bus.rs2_out;
    endcase
    w_is_div = bus.op[2];
    case (bus.op)
      OP_MUL:                     w_sel = SEL_LO;
      OP_MULH, OP_MULHSU, OP_MULHU: w_sel = SEL_HI;
      OP_DIV, OP_DIVU:            w_sel = SEL_Q;
      default:                    w_sel = SEL_R;
    endcase
    w_a_neg = w_a[WIDTH-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                               bus.op == OP_DIV  || bus.op == OP_REM);
    w_b_neg = w_b[WIDTH-1] && (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
    w_neg   = (bus.op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_a_mag = w_a_neg ? -w_a : w_a;
    w_b_mag = w_b_neg ? -w_b : w_b;
  end

`ifdef EX_MULDIV_DIV_EN
  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    if (w_is_div && (w_b == '0)) begin
      w_fast     = 1'b1;
      w_fast_res = (w_sel == SEL_Q) ? '1 : w_a;
    end else if ((bus.op == OP_DIV || bus.op == OP_REM) &&
                 (w_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&w_b)) begin
      w_fast     = 1'b1;
      w_fast_res = (bus.op == OP_DIV) ? w_a : '0;
    end
  end
`else
  always_comb begin
    w_fast     = w_is_div;
    w_fast_res = '0;
  end
`endif

  assign w_load = bus.start && !bus.flush && (r_state != ST_CALC) && !w_fast;

  ex_muldiv_unit_muldiv_core #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
`ifdef EX_MULDIV_DIV_EN
    .i_is_div  (w_is_div),
`endif
    .i_load    (w_load),
    .i_step    (r_state == ST_CALC),
    .i_lo_init (w_is_div ? w_a_mag : w_b_mag),
    .i_m       (w_is_div ? w_b_mag : w_a_mag),
    .o_hi      (w_core_hi),
    .o_lo      (w_core_lo),
    .o_last    (w_core_last)
  );

  // Signed multiply high words need the full double-width negation
  always_comb begin
    w_prod     = {w_core_hi, w_core_lo};
    w_prod_fix = r_neg ? -w_prod : w_prod;
    case (r_sel)
      SEL_LO:  w_calc_res = w_prod_fix[WIDTH-1:0];
      SEL_HI:  w_calc_res = w_prod_fix[2*WIDTH-1:WIDTH];
      SEL_Q:   w_calc_res = r_neg ? -w_core_lo : w_core_lo;
      default: w_calc_res = r_neg ? -w_core_hi : w_core_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= SEL_LO;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_CALC: begin
          if (w_core_last) begin
            r_result <= w_calc_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sel <= w_sel;
            r_neg <= w_neg;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_busy   <= 1'b1;
              r_state  <= ST_CALC;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench driving a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 unit in lockstep.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  typedef struct {
    string       name;
    muldiv_op_t  op;
    forward_t    fa;
    forward_t    fb;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exmem;
    logic [31:0] memwb;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  muldiv_op_t  opSel;
  forward_t    opaFw, opbFw;
  logic [31:0] rs1Val, rs2Val, exmemVal, memwbVal;
  logic        flushReq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(32)) if1 ();
  ex_muldiv_unit_if #(.WIDTH(32)) if4 ();

  assign if1.start = start;      assign if4.start = start;
  assign if1.op = opSel;         assign if4.op = opSel;
  assign if1.opa_fw = opaFw;     assign if4.opa_fw = opaFw;
  assign if1.opb_fw = opbFw;     assign if4.opb_fw = opbFw;
  assign if1.rs1_out = rs1Val;   assign if4.rs1_out = rs1Val;
  assign if1.rs2_out = rs2Val;   assign if4.rs2_out = rs2Val;
  assign if1.from_exmem = exmemVal; assign if4.from_exmem = exmemVal;
  assign if1.from_memwb = memwbVal; assign if4.from_memwb = memwbVal;
  assign if1.flush = flushReq;   assign if4.flush = flushReq;

  ex_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  ex_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  function automatic vec_t mk(string n, muldiv_op_t o, forward_t fa, forward_t fb,
                              logic [31:0] a, logic [31:0] b, logic [31:0] ex,
                              logic [31:0] mw, logic [31:0] e, bit f);
    vec_t v;
    v.name = n; v.op = o; v.fa = fa; v.fb = fb; v.rs1 = a; v.rs2 = b;
    v.exmem = ex; v.memwb = mw; v.exp = e; v.fast = f;
    return v;
  endfunction

  // Divide results and latency depend on whether the divider is built
  function automatic logic [31:0] dv(logic [31:0] val);
`ifdef EX_MULDIV_DIV_EN
    return val;
`else
    return 32'd0;
`endif
  endfunction

  function automatic bit dfast(bit f);
`ifdef EX_MULDIV_DIV_EN
    return f;
`else
    return 1'b1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue one op in the current cycle and follow both units until done or timeout
  task automatic applyStimulus(input vec_t v);
    int cyc = 1;
    int lat1 = 0, lat4 = 0, bz1 = 0, bz4 = 0;
    bit seen1 = 0, seen4 = 0;
    logic [31:0] res1 = '0, res4 = '0;
    start = 1'b1; opSel = v.op; opaFw = v.fa; opbFw = v.fb;
    rs1Val = v.rs1; rs2Val = v.rs2; exmemVal = v.exmem; memwbVal = v.memwb;
    @(negedge clk);
    start = 1'b0; opSel = OP_MULH;
    rs1Val = 32'hDEADBEEF; rs2Val = 32'hDEADBEEF; exmemVal = '0; memwbVal = '0;
    while (!(seen1 && seen4) && cyc <= 60) begin
      if (!seen1) begin
        if (if1.busy) bz1++;
        if (if1.done) begin seen1 = 1; lat1 = cyc; res1 = if1.result; end
      end
      if (!seen4) begin
        if (if4.busy) bz4++;
        if (if4.done) begin seen4 = 1; lat4 = cyc; res4 = if4.result; end
      end
      if (!(seen1 && seen4)) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({v.name, " bpc1 done_cycle"}, 32'(lat1), v.fast ? 32'd1 : 32'd33);
    checkOutput({v.name, " bpc1 busy_cycles"}, 32'(bz1), v.fast ? 32'd0 : 32'd32);
    checkOutput({v.name, " bpc1 result"}, res1, v.exp);
    checkOutput({v.name, " bpc4 done_cycle"}, 32'(lat4), v.fast ? 32'd1 : 32'd9);
    checkOutput({v.name, " bpc4 busy_cycles"}, 32'(bz4), v.fast ? 32'd0 : 32'd8);
    checkOutput({v.name, " bpc4 result"}, res4, v.exp);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] held1, held4;

    vecs.push_back(mk("mul_neg",    OP_MUL,    FROM_IDEX, FROM_IDEX, 32'd7, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFEB, 0));
    vecs.push_back(mk("mulhu_max",  OP_MULHU,  FROM_IDEX, FROM_IDEX, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 0));
    vecs.push_back(mk("mulh_m1",    OP_MULH,   FROM_IDEX, FROM_IDEX, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000000, 0));
    vecs.push_back(mk("mulhsu_m1",  OP_MULHSU, FROM_IDEX, FROM_IDEX, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk("mulh_minsq", OP_MULH,   FROM_IDEX, FROM_IDEX, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 0));
    vecs.push_back(mk("mul_fwd",    OP_MUL,    FROM_MEMWB, FROM_EXMEM, 32'd1, 32'd1, 32'd5, 32'd12, 32'd60, 0));
    vecs.push_back(mk("div_zero",   OP_DIV,    FROM_IDEX, FROM_IDEX, 32'd100, 32'd0, 0, 0, dv(32'hFFFFFFFF), dfast(1)));
    vecs.push_back(mk("rem_zero",   OP_REM,    FROM_IDEX, FROM_IDEX, 32'd100, 32'd0, 0, 0, dv(32'd100), dfast(1)));
    vecs.push_back(mk("div_ovf",    OP_DIV,    FROM_IDEX, FROM_IDEX, 32'h80000000, 32'hFFFFFFFF, 0, 0, dv(32'h80000000), dfast(1)));
    vecs.push_back(mk("rem_ovf",    OP_REM,    FROM_IDEX, FROM_IDEX, 32'h80000000, 32'hFFFFFFFF, 0, 0, dv(32'd0), dfast(1)));
    vecs.push_back(mk("divu_fwd",   OP_DIVU,   FROM_EXMEM, FROM_IDEX, 32'd5, 32'd7, 32'd1000, 0, dv(32'd142), dfast(0)));
    vecs.push_back(mk("rem_fwd",    OP_REM,    FROM_EXMEM, FROM_IDEX, 32'd5, 32'd7, 32'd1000, 0, dv(32'd6), dfast(0)));
    vecs.push_back(mk("div_nega",   OP_DIV,    FROM_IDEX, FROM_IDEX, 32'hFFFFFFF9, 32'd2, 0, 0, dv(32'hFFFFFFFD), dfast(0)));
    vecs.push_back(mk("rem_nega",   OP_REM,    FROM_IDEX, FROM_IDEX, 32'hFFFFFFF9, 32'd2, 0, 0, dv(32'hFFFFFFFF), dfast(0)));
    vecs.push_back(mk("div_negb",   OP_DIV,    FROM_IDEX, FROM_IDEX, 32'd7, 32'hFFFFFFFE, 0, 0, dv(32'hFFFFFFFD), dfast(0)));
    vecs.push_back(mk("rem_negb",   OP_REM,    FROM_IDEX, FROM_IDEX, 32'd7, 32'hFFFFFFFE, 0, 0, dv(32'd1), dfast(0)));
    vecs.push_back(mk("divu_zero",  OP_DIVU,   FROM_IDEX, FROM_IDEX, 32'd5, 32'd0, 0, 0, dv(32'hFFFFFFFF), dfast(1)));
    vecs.push_back(mk("remu_zero",  OP_REMU,   FROM_IDEX, FROM_IDEX, 32'd5, 32'd0, 0, 0, dv(32'd5), dfast(1)));

    rst = 1'b1; start = 1'b0; flushReq = 1'b0; opSel = OP_MUL;
    opaFw = FROM_IDEX; opbFw = FROM_IDEX;
    rs1Val = '0; rs2Val = '0; exmemVal = '0; memwbVal = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset bpc1 busy", 32'(if1.busy), 32'd0);
    checkOutput("reset bpc1 done", 32'(if1.done), 32'd0);
    checkOutput("reset bpc1 result", if1.result, 32'd0);
    checkOutput("reset bpc4 busy", 32'(if4.busy), 32'd0);
    checkOutput("reset bpc4 done", 32'(if4.done), 32'd0);
    checkOutput("reset bpc4 result", if4.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Flush in cycle 5 of a multiply: no done, result held, then a clean restart in cycle 7
    start = 1'b1; opSel = OP_MUL; opaFw = FROM_IDEX; opbFw = FROM_IDEX;
    rs1Val = 32'd3; rs2Val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("flush c5 bpc1 busy", 32'(if1.busy), 32'd1);
    checkOutput("flush c5 bpc4 busy", 32'(if4.busy), 32'd1);
    held1 = if1.result; held4 = if4.result;
    flushReq = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
    checkOutput("flush c6 bpc1 busy", 32'(if1.busy), 32'd0);
    checkOutput("flush c6 bpc4 busy", 32'(if4.busy), 32'd0);
    checkOutput("flush c6 bpc1 done", 32'(if1.done), 32'd0);
    checkOutput("flush c6 bpc4 done", 32'(if4.done), 32'd0);
    @(negedge clk);
    checkOutput("flush c7 bpc1 done", 32'(if1.done), 32'd0);
    checkOutput("flush c7 bpc4 done", 32'(if4.done), 32'd0);
    checkOutput("flush c7 bpc1 result_held", if1.result, held1);
    checkOutput("flush c7 bpc4 result_held", if4.result, held4);
    applyStimulus(mk("mul_after_flush", OP_MUL, FROM_IDEX, FROM_IDEX, 32'd6, 32'd7, 0, 0, 32'd42, 0));

    // flush together with start drops the start, for both a slow and a fast-path op
    start = 1'b1; flushReq = 1'b1; opSel = OP_MUL; rs1Val = 32'd2; rs2Val = 32'd3;
    @(negedge clk);
    start = 1'b0; flushReq = 1'b0;
    checkOutput("flush_start mul bpc1 busy", 32'(if1.busy), 32'd0);
    checkOutput("flush_start mul bpc4 busy", 32'(if4.busy), 32'd0);
    @(negedge clk);
    checkOutput("flush_start mul bpc1 done", 32'(if1.done), 32'd0);
    start = 1'b1; flushReq = 1'b1; opSel = OP_DIV; rs1Val = 32'd9; rs2Val = 32'd0;
    @(negedge clk);
    start = 1'b0; flushReq = 1'b0;
    checkOutput("flush_start div bpc1 done", 32'(if1.done), 32'd0);
    checkOutput("flush_start div bpc4 done", 32'(if4.done), 32'd0);

    // Reset in the middle of a multiply clears outputs including the held result
    start = 1'b1; opSel = OP_MUL; rs1Val = 32'd4; rs2Val = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset bpc1 busy", 32'(if1.busy), 32'd0);
    checkOutput("midreset bpc1 result", if1.result, 32'd0);
    checkOutput("midreset bpc4 busy", 32'(if4.busy), 32'd0);
    checkOutput("midreset bpc4 result", if4.result, 32'd0);
    applyStimulus(mk("mul_recover", OP_MUL, FROM_IDEX, FROM_IDEX, 32'd9, 32'd9, 0, 0, 32'd81, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
